// File: rtl/serial_eq_neq_comparator.sv
// Bit-serial EQ/NEQ comparator: consumes WIDTH LSB-first bit-pairs and reports a select-steered result.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the compare on the first mismatching pair.
module serial_eq_neq_comparator #(
  parameter int unsigned WIDTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic select,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic s
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          mismatch;
  logic          sel_q;

  logic pair_mis_c;
  logic last_pair_c;

  assign pair_mis_c  = a_bit ^ b_bit;
  assign last_pair_c = (count == CW'(WIDTH - 1));

  // Control, datapath and registered outputs share one sequential block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      mismatch <= 1'b0;
      sel_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A pair presented alongside start is deliberately not counted.
          if (start) begin
            sel_q    <= select;
            mismatch <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            mismatch <= mismatch | pair_mis_c;
            if (count != CW'(WIDTH)) begin
              count <= count + CW'(1);
            end
            if (last_pair_c) begin
              busy  <= 1'b0;
              state <= DONE;
            end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            else if (pair_mis_c) begin
              busy  <= 1'b0;
              state <= DONE;
            end
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          s     <= sel_q ? mismatch : ~mismatch;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_neq_comparator.sv
// Directed self-checking bench for serial_eq_neq_comparator (WIDTH=6).
module tb_serial_eq_neq_comparator;

  localparam int unsigned WIDTH = 6;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, select, bit_valid, a_bit, b_bit;
  logic busy, done, s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_eq_neq_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .select   (select),
    .bit_valid(bit_valid),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .busy     (busy),
    .done     (done),
    .s        (s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one compare; cycle numbers count edges after the start edge. No checking here.
  task automatic drive_compare(input logic [5:0] a, input logic [5:0] b, input logic sel,
                               input int stall_at, input int stall_len, input int poke_cyc,
                               input logic junk, output int done_cyc, output logic s_out,
                               output logic s_pre);
    int idx;
    int stalled;
    idx = 0;
    stalled = 0;
    start = 1'b1; select = sel; bit_valid = junk; a_bit = junk; b_bit = 1'b0;
    tick();
    start = 1'b0; select = ~sel; s_pre = s;
    done_cyc = -1; s_out = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      bit_valid = 1'b0;
      if (busy && idx < int'(WIDTH)) begin
        if (idx == stall_at && stalled < stall_len) begin
          stalled++;
        end else begin
          bit_valid = 1'b1;
          a_bit = a[3'(idx)];
          b_bit = b[3'(idx)];
          idx++;
        end
      end
      start = (c == poke_cyc);
      tick();
      if (done) begin
        done_cyc = c;
        s_out = s;
        break;
      end
    end
    start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); select = 1'($urandom); bit_valid = 1'($urandom);
      a_bit = 1'($urandom); b_bit = 1'($urandom);
      tick();
      total++;
      if ({busy, done, s} !== 3'b000) begin
        bad++; $display("FAIL reset_hold outs got=%b want=000", {busy, done, s});
      end
    end
    start = 1'b0; bit_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({busy, done, s} !== 3'b000) begin
        bad++; $display("FAIL reset_release outs got=%b want=000", {busy, done, s});
      end
    end
  endtask

  task automatic test_eq();
    int dc; logic so, sp;
    drive_compare(6'h0F, 6'h0F, 1'b0, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (sp !== 1'b0) begin bad++; $display("FAIL eq_s_before got=%b want=0", sp); end
    total++; if (dc !== 7) begin bad++; $display("FAIL eq_done_cycle got=%0d want=7", dc); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL eq_sel0_s got=%b want=1", so); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL eq_done_pulse got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_busy_after got=%b want=0", busy); end
    drive_compare(6'h0F, 6'h0F, 1'b1, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (dc !== 7) begin bad++; $display("FAIL eq_sel1_done_cycle got=%0d want=7", dc); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL eq_sel1_s got=%b want=0", so); end
    tick();
  endtask

  task automatic test_neq_lsb();
    int dc; logic so, sp;
    drive_compare(6'h0F, 6'h0E, 1'b1, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (dc !== (EARLY ? 2 : 7)) begin
      bad++; $display("FAIL neq_done_cycle got=%0d want=%0d", dc, EARLY ? 2 : 7);
    end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL neq_sel1_s got=%b want=1", so); end
    tick();
    drive_compare(6'h0F, 6'h0E, 1'b0, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (dc !== (EARLY ? 2 : 7)) begin
      bad++; $display("FAIL neq_sel0_done_cycle got=%0d want=%0d", dc, EARLY ? 2 : 7);
    end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL neq_sel0_s got=%b want=0", so); end
    tick();
  endtask

  task automatic test_stall();
    int dc; logic so, sp;
    drive_compare(6'h2A, 6'h2A, 1'b0, 3, 3, 2, 1'b0, dc, so, sp);
    total++; if (dc !== 10) begin bad++; $display("FAIL stall_done_cycle got=%0d want=10", dc); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL stall_s got=%b want=1", so); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] a, b;
    int dc, ndone; logic so, sp;
    a = 6'h3F; b = 6'h1F; ndone = 0;
    start = 1'b1; select = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      tick();
    end
    bit_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, s} !== 3'b000) begin
      bad++; $display("FAIL midrst_async outs got=%b want=000", {busy, done, s});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
    total++; if ({busy, s} !== 2'b00) begin
      bad++; $display("FAIL midrst_idle outs got=%b want=00", {busy, s});
    end
    drive_compare(6'h05, 6'h05, 1'b0, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (dc !== 7) begin bad++; $display("FAIL midrst_fresh_cycle got=%0d want=7", dc); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL midrst_fresh_s got=%b want=1", so); end
    tick();
  endtask

  task automatic test_back_to_back();
    int dc; logic so, sp;
    drive_compare(6'h11, 6'h11, 1'b0, -1, 0, 7, 1'b0, dc, so, sp);
    total++; if (dc !== 7) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=7", dc); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL b2b_first_s got=%b want=1", so); end
    tick();
    total++; if ({busy, done, s} !== 3'b001) begin
      bad++; $display("FAIL b2b_start_in_done outs got=%b want=001", {busy, done, s});
    end
    drive_compare(6'h11, 6'h12, 1'b0, -1, 0, -1, 1'b0, dc, so, sp);
    total++; if (sp !== 1'b1) begin bad++; $display("FAIL b2b_s_held got=%b want=1", sp); end
    total++; if (dc !== 7 - 6 * 0 && !(EARLY == 1 && dc == 2)) begin
      bad++; $display("FAIL b2b_second_cycle got=%0d want=%0d", dc, EARLY ? 2 : 7);
    end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL b2b_second_s got=%b want=0", so); end
    tick();
  endtask

  task automatic test_idle_noise();
    int dc; logic so, sp;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; start = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL idle_noise outs got=%b want=00", {busy, done});
    end
    drive_compare(6'h15, 6'h15, 1'b0, -1, 0, -1, 1'b1, dc, so, sp);
    total++; if (dc !== 7) begin bad++; $display("FAIL start_pair_cycle got=%0d want=7", dc); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL start_pair_s got=%b want=1", so); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; select = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    test_reset();
    test_eq();
    test_neq_lsb();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_idle_noise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
